booth4_mul_seq: RTL and testbench

- Sequential signed multiplier using radix-4 Booth recoding. It computes a WIDTH x WIDTH two's-complement product over WIDTH/2 iterations.
- It sits directly upstream of the 34-bit lane of the shared add/subtract unit. Each cycle it drives that lane's operands and carry-in, and consumes its sum.
- The block contains no adder; the accumulator update comes from add_sum.

---
 rtl/booth4_mul_seq.sv | 118 +++++++++++
 tb/tb_booth4_mul_seq.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/booth4_mul_seq.sv
// Sequential radix-4 Booth signed multiplier; WIDTH/2 iterations, drives an
// external WIDTH+2 bit add/subtract lane and consumes its sum the same cycle.
module booth4_mul_seq #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product,
    output logic [WIDTH+1:0]     add_x,
    output logic [WIDTH+1:0]     add_y,
    output logic                 add_cin,
    input  logic [WIDTH+1:0]     add_sum
);

    // state | meaning
    // IDLE  | waiting for start; operands captured on accept
    // RUN   | one Booth digit per cycle, WIDTH/2 cycles
    // DONE  | product valid, done pulses for this single cycle

    localparam int AW   = WIDTH + 2;
    localparam int HALF = WIDTH / 2;
    localparam int CW   = (HALF > 1) ? $clog2(HALF) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [AW-1:0]     a_reg;
    logic [AW-1:0]     mx;
    logic [WIDTH-1:0]  q_reg;
    logic              q_m1;
    logic [CW-1:0]     count;
    logic              last_iter;
    logic [AW-1:0]     a_new;
    logic [WIDTH-1:0]  q_new;

    assign last_iter = (count == CW'(HALF - 1));

    // Arithmetic shift right by two of {add_sum, Q, q_m1}; q_m1 becomes Q[1].
    assign a_new = {add_sum[AW-1], add_sum[AW-1], add_sum[AW-1:2]};
    assign q_new = {add_sum[1:0], q_reg[WIDTH-1:2]};

    assign add_x = a_reg;
    assign busy  = (state != IDLE);
    assign done  = (state == DONE);

    always_comb begin
        state_nxt = state;
        add_y     = '0;
        add_cin   = 1'b0;
        case (state)
            IDLE: if (start) state_nxt = RUN;
            RUN: begin
                case ({q_reg[1:0], q_m1})
                    3'b001, 3'b010: add_y = mx;
                    3'b011:         add_y = {mx[AW-2:0], 1'b0};
                    3'b100: begin
                        add_y   = {mx[AW-2:0], 1'b0};
                        add_cin = 1'b1;
                    end
                    3'b101, 3'b110: begin
                        add_y   = mx;
                        add_cin = 1'b1;
                    end
                    default: begin
                        add_y   = '0;
                        add_cin = 1'b0;
                    end
                endcase
                if (last_iter) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            a_reg   <= '0;
            mx      <= '0;
            q_reg   <= '0;
            q_m1    <= 1'b0;
            count   <= '0;
            product <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_reg <= '0;
                        q_reg <= multiplier;
                        q_m1  <= 1'b0;
                        mx    <= {{2{multiplicand[WIDTH-1]}}, multiplicand};
                        count <= '0;
                    end
                end
                RUN: begin
                    a_reg <= a_new;
                    q_reg <= q_new;
                    q_m1  <= q_reg[1];
                    count <= last_iter ? '0 : count + CW'(1);
                    if (last_iter) product <= {a_new[WIDTH-1:0], q_new};
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_booth4_mul_seq.sv
// Directed bench for booth4_mul_seq with a behavioural model of the external
// add/subtract lane; hand-computed products plus multi-cycle corner sequences.
module tb_booth4_mul_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] multiplicand;
    logic [31:0] multiplier;
    logic        busy;
    logic        done;
    logic [63:0] product;
    logic [33:0] add_x;
    logic [33:0] add_y;
    logic        add_cin;
    logic [33:0] add_sum;

    int errors = 0;
    int checks = 0;

    booth4_mul_seq #(.WIDTH(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .busy         (busy),
        .done         (done),
        .product      (product),
        .add_x        (add_x),
        .add_y        (add_y),
        .add_cin      (add_cin),
        .add_sum      (add_sum)
    );

    // Shared lane: X + (Y xor cin) + cin.
    assign add_sum = add_x + (add_y ^ {34{add_cin}}) + {33'b0, add_cin};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] m;
        logic [31:0] q;
        logic [63:0] p;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
        end
    endtask

    task automatic start_op(input logic [31:0] m, input logic [31:0] q);
        @(negedge clk);
        multiplicand = m;
        multiplier   = q;
        start        = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Called just after the accept edge; done must be seen after the 16th edge.
    task automatic wait_done(input string name, input logic [63:0] exp_p);
        int  n;
        bit  seen;
        n    = 0;
        seen = 0;
        while (!seen && n < 40) begin
            @(posedge clk);
            #1;
            n++;
            if (done) seen = 1;
        end
        check({name, " latency"}, 64'(n), 64'd16);
        check({name, " product"}, product, exp_p);
        @(posedge clk);
        #1;
        check({name, " done_pulse"}, {63'b0, done}, 64'd0);
        check({name, " idle"}, {63'b0, busy}, 64'd0);
    endtask

    initial begin
        int bc;
        int dn_at;
        int dn_cnt;

        vecs[0] = '{32'hFFFF_FFF9, 32'h0000_0006, 64'hFFFF_FFFF_FFFF_FFD6};
        vecs[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001};
        vecs[2] = '{32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000};
        vecs[3] = '{32'h7FFF_FFFF, 32'h8000_0000, 64'hC000_0000_8000_0000};
        vecs[4] = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 64'h3FFF_FFFF_0000_0001};
        vecs[5] = '{32'h0000_0000, 32'h1234_5678, 64'h0000_0000_0000_0000};
        vecs[6] = '{32'h1234_5678, 32'h0000_0010, 64'h0000_0001_2345_6780};
        vecs[7] = '{32'hFFFF_FFFF, 32'h8000_0000, 64'h0000_0000_8000_0000};

        rst_n        = 1'b0;
        start        = 1'b0;
        multiplicand = '0;
        multiplier   = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst busy", {63'b0, busy}, 64'd0);
        check("rst done", {63'b0, done}, 64'd0);
        check("rst product", product, 64'd0);
        check("rst add_x", {30'b0, add_x}, 64'd0);
        check("rst add_y", {30'b0, add_y}, 64'd0);
        check("rst add_cin", {63'b0, add_cin}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // 3 x 5 with explicit busy/done timing
        start_op(32'd3, 32'd5);
        bc     = busy ? 1 : 0;
        dn_at  = -1;
        dn_cnt = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (busy) bc++;
            if (done) begin
                dn_cnt++;
                if (dn_at < 0) dn_at = i;
            end
        end
        check("t1 busy_cycles", 64'(bc), 64'd17);
        check("t1 done_edge", 64'(dn_at), 64'd16);
        check("t1 done_count", 64'(dn_cnt), 64'd1);
        check("t1 product", product, 64'h0000_0000_0000_000F);

        for (int i = 0; i < 8; i++) begin
            start_op(vecs[i].m, vecs[i].q);
            wait_done($sformatf("vec%0d", i), vecs[i].p);
        end

        // start held high across the run with changed operands
        @(negedge clk);
        multiplicand = 32'd7;
        multiplier   = 32'd9;
        start        = 1'b1;
        @(posedge clk);
        #1;
        multiplicand = 32'd2;
        multiplier   = 32'd2;
        wait_done("t4a", 64'd63);
        @(posedge clk);
        #1;
        check("t4 reaccept busy", {63'b0, busy}, 64'd1);
        check("t4 product held", product, 64'd63);
        start = 1'b0;
        wait_done("t4b", 64'd4);

        // reset in the middle of a run
        start_op(32'd100, 32'd3);
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("t5 busy", {63'b0, busy}, 64'd0);
        check("t5 done", {63'b0, done}, 64'd0);
        check("t5 product", product, 64'd0);
        check("t5 add_x", {30'b0, add_x}, 64'd0);
        repeat (2) @(negedge clk);
        rst_n  = 1'b1;
        dn_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (done) dn_cnt++;
        end
        check("t5 no_done", 64'(dn_cnt), 64'd0);
        check("t5 idle", {63'b0, busy}, 64'd0);
        start_op(32'd12, 32'hFFFF_FFF4);
        wait_done("t5 rerun", 64'hFFFF_FFFF_FFFF_FF70);

        // first iteration of 1 x 2 uses Booth code 100
        start_op(32'd1, 32'd2);
        check("t6 add_cin", {63'b0, add_cin}, 64'd1);
        check("t6 add_y", {30'b0, add_y}, 64'h2);
        check("t6 add_x", {30'b0, add_x}, 64'd0);
        wait_done("t6", 64'd2);
        check("t6 idle add_y", {30'b0, add_y}, 64'd0);
        check("t6 idle add_cin", {63'b0, add_cin}, 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
